alu_result_monitor: RTL and testbench
=====================================

Name: alu_result_monitor

Overview:
- Receive-side counterpart to the ALU stimulus BFM: samples ALU result buses (out, carry_out, compare flags) together with the applied select code, on a sample strobe.
- Arm/trigger capture FSM qualifies which samples are recorded; captured records are buffered in a FIFO and drained through a valid/ready read port.
- Sits between the ALU array (DUT outputs) and the checker or scoreboard logic in the verification/debug harness.

Parameters:
- WIDTH, 4, bit width of one ALU slice.
- N_ALU, 4, number of ALU slices; result bus width OUT_W = WIDTH*N_ALU*8.
- DEPTH, 8, FIFO depth in records; power of two, minimum 2.
- CAPT_LEN, 16, qualified samples per capture window; range 1..65535.

Ports:
- clk  in  1  clock
- arst  in  1  reset; synchronous, active-high
- sample_valid  in  1  ALU outputs valid this cycle
- select  in  3  opcode applied to the ALU
- out  in  OUT_W  ALU result bus
- carry_out  in  1  ALU carry
- a_greater, a_equal, a_less  in  1 each  compare flags
- arm  in  1  pulse; IDLE->ARMED
- abort  in  1  pulse; return to IDLE
- clear  in  1  pulse; flush FIFO and statistics
- trig_en  in  1  1: trigger on select==trig_sel; 0: trigger on first sample_valid
- trig_sel  in  3  trigger opcode
- rd_valid  out  1  FIFO non-empty
- rd_ready  in  1  consumer accepts head record
- rd_data  out  REC_W  {select, carry_out, a_greater, a_equal, a_less, out}; REC_W = OUT_W+7
- state  out  2  FSM state code
- cap_cnt  out  16  qualified samples in current window
- overflow  out  1  sticky; a sample was dropped because the FIFO was full
- drop_cnt  out  8  dropped samples, saturating at 255
- done  out  1  high while in DONE

Behaviour:
- Reset, synchronous on arst=1 at the clk edge: state=IDLE(0), FIFO empty, rd_valid=0, rd_data=0, cap_cnt=0, overflow=0, drop_cnt=0, done=0. Reset mid-capture discards all records.
- FSM states: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
  - IDLE->ARMED on arm.
  - ARMED->CAPTURE on sample_valid & (!trig_en | select==trig_sel). The trigger sample itself is qualified and pushed.
  - CAPTURE: every sample_valid is a qualified sample. CAPTURE->DONE in the cycle cap_cnt reaches CAPT_LEN.
  - DONE->ARMED on arm, which also sets cap_cnt=0.
  - abort moves any state to IDLE and has priority over arm.
  - arm in ARMED or CAPTURE is ignored.
- cap_cnt counts qualified samples, including dropped ones. The capture window is sample-based, not storage-based. cap_cnt clears on the IDLE->ARMED and DONE->ARMED transitions.
- Push: a qualified sample writes the record at the clk edge. The record is visible on rd_data/rd_valid in the next cycle; there is no same-cycle bypass.
- Pop: rd_valid & rd_ready advances the head at the clk edge. rd_data is first-word fall-through and is held stable while rd_valid & !rd_ready.
- Full: a push is accepted only if a pop occurs in the same cycle. Otherwise the record is dropped, overflow is set, and drop_cnt increments (saturating at 255).
- Empty: rd_valid=0 and rd_data holds its last value. Simultaneous push and pop when empty cannot occur (no bypass).
- Pointers are log2(DEPTH) bits wide and wrap naturally. Occupancy counter is log2(DEPTH)+1 bits.
- clear empties the FIFO and zeroes overflow and drop_cnt; state and cap_cnt are unaffected. clear takes priority over a same-cycle push and pop.
- Priority order: arst > abort/clear > arm > sample.

Optional Feature:
- Macro: ALU_MON_MISR_EN.
- Defined:
  - Adds output signature [31:0].
  - A 32-bit MISR, polynomial 0x04C11DB7, compacts each accepted record. The record is XOR-folded to 32 bits in 32-bit chunks, LSB chunk first, zero-padded.
  - Seed 0xFFFFFFFF on reset, clear, and each arm.
- Undefined: no port and no MISR logic.

Decomposition:
- Package alu_mon_pkg:
  - state enum alu_mon_state_e.
  - Packed struct alu_mon_rec_t (select, carry, gt, eq, lt, out), parameterized via a width localparam.
  - MISR polynomial and seed constants.
- Sub-module alu_mon_fifo:
  - Generic synchronous FWFT FIFO (DATA_W, DEPTH).
  - Ports: push, pop, clear, full, empty, dout.
- Top level holds the FSM, counters, and the MISR.

Test Plan:
- Reset/arm: arst=1 for 2 cycles -> all outputs 0, state=0. arm -> state=1. sample_valid with select=5, trig_en=0 -> state=2, rd_valid=1 next cycle, rd_data select field=5.
- Trigger: trig_en=1, trig_sel=3; samples with select 1,2,3,4 -> first captured record has select=3, cap_cnt=2 after select=4.
- Window end: CAPT_LEN=4 with continuous sample_valid and rd_ready=1 -> done=1 after the 4th sample, exactly 4 records read, 5th sample ignored.
- Overflow: DEPTH=8, rd_ready=0, 10 samples -> rd_valid=1, overflow=1, drop_cnt=2. Then rd_ready=1 -> 8 records in order. Full with simultaneous pop and push -> record accepted, drop_cnt unchanged.
- Abort/clear: abort mid-CAPTURE -> state=0, FIFO retained. clear -> rd_valid=0, overflow=0, drop_cnt=0. arst during CAPTURE -> empty, state=0.
- MISR (ALU_MON_MISR_EN): arm, capture one all-zero record -> signature equals the golden value from the reference model. Re-arm -> signature=0xFFFFFFFF.

Source files
------------

// File: rtl/alu_mon_pkg.sv
// Shared types and constants for the ALU result monitor: FSM states, record layout, MISR constants.
package alu_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } alu_mon_state_e;

   // Record layout for the default geometry (WIDTH=4, N_ALU=4)
   localparam int unsigned ALU_MON_OUT_W = 4 * 4 * 8;

   typedef struct packed {
      logic [2:0]               select;
      logic                     carry;
      logic                     gt;
      logic                     eq;
      logic                     lt;
      logic [ALU_MON_OUT_W-1:0] out;
   } alu_mon_rec_t;

   localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
   localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;

   function automatic logic [31:0] misr_step(input logic [31:0] sig, input logic [31:0] din);
      return {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0) ^ din;
   endfunction

endpackage

// File: rtl/alu_result_monitor_if.sv
// Sample and read-port bundle between the ALU array, the monitor and its consumer.
interface alu_result_monitor_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned N_ALU = 4
);
   localparam int unsigned OUT_W = WIDTH * N_ALU * 8;
   localparam int unsigned REC_W = OUT_W + 7;

   logic             sample_valid;
   logic [2:0]       select;
   logic [OUT_W-1:0] out;
   logic             carry_out;
   logic             a_greater;
   logic             a_equal;
   logic             a_less;
   logic             rd_valid;
   logic             rd_ready;
   logic [REC_W-1:0] rd_data;

   modport master (
      output sample_valid, select, out, carry_out, a_greater, a_equal, a_less, rd_ready,
      input  rd_valid, rd_data
   );

   modport slave (
      input  sample_valid, select, out, carry_out, a_greater, a_equal, a_less, rd_ready,
      output rd_valid, rd_data
   );

endinterface

// File: rtl/alu_mon_fifo.sv
// Synchronous first-word-fall-through FIFO with registered head output; head holds its
// last value while empty and a push into an empty FIFO appears on dout one cycle later.
module alu_mon_fifo #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              clear,
   input  logic [DATA_W-1:0] din,
   output logic              full,
   output logic              empty,
   output logic [DATA_W-1:0] dout
);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  rd_nxt;
   logic [PTR_W:0]    count;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_nxt  = rd_ptr + PTR_W'(1);

   always_ff @(posedge clk) begin
      if (do_push && !clear)
         mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         dout   <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)
            rd_ptr <= rd_nxt;
         if (do_push && !do_pop)
            count <= count + (PTR_W+1)'(1);
         else if (do_pop && !do_push)
            count <= count - (PTR_W+1)'(1);
         // Head register: load the incoming word when it becomes the head, else the next stored entry
         if (do_push && (empty || (do_pop && count == (PTR_W+1)'(1))))
            dout <= din;
         else if (do_pop && count > (PTR_W+1)'(1))
            dout <= mem[rd_nxt];
      end
   end

endmodule

// File: rtl/alu_result_monitor.sv
// ALU result monitor: arm/trigger capture FSM feeding a record FIFO drained via valid/ready.
// Optional macro ALU_MON_MISR_EN adds a 32-bit MISR signature of every accepted record.
module alu_result_monitor
   import alu_mon_pkg::*;
#(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned N_ALU    = 4,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned CAPT_LEN = 16
) (
   input  logic                 clk,
   input  logic                 arst,
   alu_result_monitor_if.slave  bus,
   input  logic                 arm,
   input  logic                 abort,
   input  logic                 clear,
   input  logic                 trig_en,
   input  logic [2:0]           trig_sel,
   output logic [1:0]           state,
   output logic [15:0]          cap_cnt,
   output logic                 overflow,
   output logic [7:0]           drop_cnt,
`ifdef ALU_MON_MISR_EN
   output logic [31:0]          signature,
`endif
   output logic                 done
);
   localparam int unsigned OUT_W = WIDTH * N_ALU * 8;
   localparam int unsigned REC_W = OUT_W + 7;

   alu_mon_state_e   st;
   logic [REC_W-1:0] rec;
   logic             fifo_full;
   logic             fifo_empty;
   logic             rd_pop;
   logic             trig_hit;
   logic             qual;
   logic             push_ok;
   logic             cap_last;
   logic [15:0]      cap_inc;

   assign rec          = {bus.select, bus.carry_out, bus.a_greater, bus.a_equal, bus.a_less, bus.out};
   assign bus.rd_valid = !fifo_empty;
   assign rd_pop       = !fifo_empty && bus.rd_ready;
   assign trig_hit     = !trig_en || (bus.select == trig_sel);
   // abort wins over a same-cycle sample, so the sample is not qualified
   assign qual         = !abort && bus.sample_valid &&
                         (((st == ST_ARMED) && trig_hit) || (st == ST_CAPTURE));
   assign push_ok      = qual && !clear && (!fifo_full || rd_pop);
   assign cap_inc      = cap_cnt + 16'd1;
   assign cap_last     = (cap_inc == 16'(CAPT_LEN));
   assign state        = st;

   alu_mon_fifo #(
      .DATA_W (REC_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (arst),
      .push  (push_ok),
      .pop   (rd_pop),
      .clear (clear),
      .din   (rec),
      .full  (fifo_full),
      .empty (fifo_empty),
      .dout  (bus.rd_data)
   );

   always_ff @(posedge clk) begin
      if (arst) begin
         st      <= ST_IDLE;
         cap_cnt <= '0;
         done    <= 1'b0;
      end else if (abort) begin
         st   <= ST_IDLE;
         done <= 1'b0;
      end else begin
         case (st)
            ST_IDLE: begin
               if (arm) begin
                  st      <= ST_ARMED;
                  cap_cnt <= '0;
               end
            end
            ST_ARMED, ST_CAPTURE: begin
               if (qual) begin
                  cap_cnt <= cap_inc;
                  if (cap_last) begin
                     st   <= ST_DONE;
                     done <= 1'b1;
                  end else begin
                     st <= ST_CAPTURE;
                  end
               end
            end
            ST_DONE: begin
               if (arm) begin
                  st      <= ST_ARMED;
                  cap_cnt <= '0;
                  done    <= 1'b0;
               end
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (arst || clear) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (qual && fifo_full && !rd_pop) begin
         overflow <= 1'b1;
         if (drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
      end
   end

`ifdef ALU_MON_MISR_EN
   localparam int unsigned N_CHUNK = (REC_W + 31) / 32;
   localparam int unsigned PAD_W   = N_CHUNK * 32;

   logic [PAD_W-1:0] rec_pad;
   logic [31:0]      rec_fold;
   logic             seed_evt;

   assign seed_evt = arm && !abort && ((st == ST_IDLE) || (st == ST_DONE));

   always_comb begin
      rec_pad  = PAD_W'(rec);
      rec_fold = '0;
      for (int unsigned i = 0; i < N_CHUNK; i++)
         rec_fold = rec_fold ^ rec_pad[i*32 +: 32];
   end

   always_ff @(posedge clk) begin
      if (arst || clear || seed_evt)
         signature <= MISR_SEED;
      else if (push_ok)
         signature <= misr_step(signature, rec_fold);
   end
`endif

endmodule

// File: tb/tb_alu_result_monitor.sv
// Randomized self-checking bench for alu_result_monitor against a queue-based reference model.
// Build with ALU_MON_MISR_EN defined to also check the signature output.
module tb_alu_result_monitor;
   import alu_mon_pkg::*;

   localparam int unsigned DEPTH    = 8;
   localparam int unsigned CAPT_LEN = 12;

   logic        clk = 1'b0;
   logic        arst;
   logic        arm;
   logic        abort;
   logic        clear;
   logic        trig_en;
   logic [2:0]  trig_sel;
   logic [1:0]  state;
   logic [15:0] cap_cnt;
   logic        overflow;
   logic [7:0]  drop_cnt;
   logic        done;
`ifdef ALU_MON_MISR_EN
   logic [31:0] signature;
`endif

   alu_result_monitor_if #(.WIDTH(4), .N_ALU(4)) bus ();

   alu_result_monitor #(
      .WIDTH    (4),
      .N_ALU    (4),
      .DEPTH    (DEPTH),
      .CAPT_LEN (CAPT_LEN)
   ) dut (
      .clk       (clk),
      .arst      (arst),
      .bus       (bus),
      .arm       (arm),
      .abort     (abort),
      .clear     (clear),
      .trig_en   (trig_en),
      .trig_sel  (trig_sel),
      .state     (state),
      .cap_cnt   (cap_cnt),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt),
`ifdef ALU_MON_MISR_EN
      .signature (signature),
`endif
      .done      (done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: state code, record queue, shown head, counters, signature
   int           m_st;
   int           m_cap;
   int           m_drops;
   bit           m_ov;
   alu_mon_rec_t m_q[$];
   alu_mon_rec_t m_shown;
   logic [31:0]  m_sig;

   task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [31:0] ref_misr(input logic [31:0] s, input alu_mon_rec_t r);
      logic [159:0] p;
      logic [31:0]  d;
      p = 160'(r);
      d = 32'h0;
      for (int k = 0; k < 5; k++) d = d ^ p[k*32 +: 32];
      return (s << 1) ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ d;
   endfunction

   task automatic model_step();
      alu_mon_rec_t r;
      bit pop, qual, hit, full;
      r.select = bus.select;
      r.carry  = bus.carry_out;
      r.gt     = bus.a_greater;
      r.eq     = bus.a_equal;
      r.lt     = bus.a_less;
      r.out    = bus.out;
      pop  = (m_q.size() > 0) && bus.rd_ready;
      hit  = !trig_en || (bus.select == trig_sel);
      qual = !abort && bus.sample_valid && ((m_st == 1 && hit) || m_st == 2);
      if (arst) begin
         m_st = 0; m_cap = 0; m_drops = 0; m_ov = 0;
         m_q.delete(); m_shown = '0; m_sig = 32'hFFFFFFFF;
         return;
      end
      if (clear) begin
         m_q.delete(); m_ov = 0; m_drops = 0; m_sig = 32'hFFFFFFFF;
      end else begin
         full = (m_q.size() == DEPTH);
         if (pop) void'(m_q.pop_front());
         if (qual) begin
            if (!full || pop) begin
               m_q.push_back(r);
               m_sig = ref_misr(m_sig, r);
            end else begin
               m_ov = 1;
               if (m_drops < 255) m_drops++;
            end
         end
      end
      if (m_q.size() > 0) m_shown = m_q[0];
      if (abort) m_st = 0;
      else if ((m_st == 0 || m_st == 3) && arm) begin
         m_st = 1; m_cap = 0; m_sig = 32'hFFFFFFFF;
      end else if (qual) begin
         m_cap++;
         m_st = (m_cap == CAPT_LEN) ? 3 : 2;
      end
   endtask

   task automatic compare_all();
      check_val("state", state, m_st);
      check_val("cap_cnt", cap_cnt, m_cap);
      check_val("rd_valid", bus.rd_valid, m_q.size() > 0);
      check_val("rd_data", bus.rd_data, m_shown);
      check_val("overflow", overflow, m_ov);
      check_val("drop_cnt", drop_cnt, m_drops);
      check_val("done", done, m_st == 3);
`ifdef ALU_MON_MISR_EN
      check_val("signature", signature, m_sig);
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic idle_inputs();
      arst = 0; arm = 0; abort = 0; clear = 0;
      bus.sample_valid = 0;
   endtask

   task automatic drive_sample(input logic [2:0] sel);
      bus.sample_valid = 1;
      bus.select       = sel;
      bus.out          = {$urandom, $urandom, $urandom, $urandom};
      bus.carry_out    = 1'($urandom);
      bus.a_greater    = 1'($urandom);
      bus.a_equal      = 1'($urandom);
      bus.a_less       = 1'($urandom);
   endtask

   initial begin
      int pops;
      idle_inputs();
      trig_en = 0; trig_sel = 0; bus.rd_ready = 0;
      bus.select = 0; bus.out = '0; bus.carry_out = 0;
      bus.a_greater = 0; bus.a_equal = 0; bus.a_less = 0;
      m_st = 0; m_cap = 0; m_drops = 0; m_ov = 0; m_shown = '0; m_sig = 32'hFFFFFFFF;

      // Reset, arm, untriggered first sample
      arst = 1; tick(); tick(); arst = 0;
      check_val("rst_state", state, 0);
      check_val("rst_rd_data", bus.rd_data, 0);
      check_val("rst_rd_valid", bus.rd_valid, 0);
      arm = 1; tick(); arm = 0;
      check_val("arm_state", state, 1);
      drive_sample(3'd5); tick(); idle_inputs();
      check_val("first_state", state, 2);
      check_val("first_rd_valid", bus.rd_valid, 1);
      check_val("first_select", bus.rd_data[134:132], 5);

      // Opcode trigger
      abort = 1; clear = 1; tick(); idle_inputs();
      arm = 1; tick(); arm = 0;
      trig_en = 1; trig_sel = 3;
      for (int s = 1; s <= 4; s++) begin drive_sample(3'(s)); tick(); end
      idle_inputs();
      check_val("trig_head_select", bus.rd_data[134:132], 3);
      check_val("trig_cap_cnt", cap_cnt, 2);

      // Window end with continuous reading
      abort = 1; clear = 1; tick(); idle_inputs();
      arm = 1; tick(); arm = 0;
      trig_en = 0; bus.rd_ready = 1; pops = 0;
      for (int s = 0; s < CAPT_LEN + 1; s++) begin
         drive_sample(3'($urandom));
         if (bus.rd_valid) pops++;
         tick();
      end
      idle_inputs();
      for (int s = 0; s < 3; s++) begin
         if (bus.rd_valid) pops++;
         tick();
      end
      check_val("window_done", done, 1);
      check_val("window_pops", pops, CAPT_LEN);

      // Overflow then drain in order
      clear = 1; arm = 1; bus.rd_ready = 0; tick(); idle_inputs();
      for (int s = 0; s < 10; s++) begin drive_sample(3'($urandom)); tick(); end
      idle_inputs();
      check_val("ovf_rd_valid", bus.rd_valid, 1);
      check_val("ovf_flag", overflow, 1);
      check_val("ovf_drop_cnt", drop_cnt, 2);
      bus.rd_ready = 1; pops = 0;
      for (int s = 0; s < 10; s++) begin
         if (bus.rd_valid) pops++;
         tick();
      end
      check_val("drain_pops", pops, DEPTH);

      // Full FIFO with simultaneous pop and push
      abort = 1; clear = 1; tick(); idle_inputs();
      arm = 1; bus.rd_ready = 0; tick(); arm = 0;
      for (int s = 0; s < DEPTH; s++) begin drive_sample(3'($urandom)); tick(); end
      bus.rd_ready = 1; drive_sample(3'd6); tick();
      check_val("full_pp_drop_cnt", drop_cnt, 0);
      check_val("full_pp_overflow", overflow, 0);
      bus.rd_ready = 0; drive_sample(3'd2); tick(); idle_inputs();
      check_val("full_drop_cnt", drop_cnt, 1);

      // Abort retains FIFO, clear empties it, arst mid-capture
      abort = 1; tick(); idle_inputs();
      check_val("abort_state", state, 0);
      check_val("abort_rd_valid", bus.rd_valid, 1);
      clear = 1; tick(); idle_inputs();
      check_val("clear_rd_valid", bus.rd_valid, 0);
      check_val("clear_drop_cnt", drop_cnt, 0);
      arm = 1; tick(); arm = 0;
      drive_sample(3'd1); tick(); drive_sample(3'd4); tick(); idle_inputs();
      arst = 1; tick(); arst = 0;
      check_val("arst_rd_valid", bus.rd_valid, 0);
      check_val("arst_state", state, 0);

`ifdef ALU_MON_MISR_EN
      // Signature of one all-zero record, then reseed on re-arm
      arm = 1; tick(); arm = 0;
      bus.sample_valid = 1; bus.select = 0; bus.out = '0; bus.carry_out = 0;
      bus.a_greater = 0; bus.a_equal = 0; bus.a_less = 0;
      tick(); idle_inputs();
      check_val("misr_zero_rec", signature, ref_misr(32'hFFFFFFFF, '0));
      abort = 1; tick(); idle_inputs();
      arm = 1; tick(); arm = 0;
      check_val("misr_reseed", signature, 32'hFFFFFFFF);
`endif

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         arst  = ($urandom_range(0, 299) == 0);
         abort = ($urandom_range(0, 59) == 0);
         clear = ($urandom_range(0, 79) == 0);
         arm   = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 49) == 0) begin
            trig_en  = 1'($urandom);
            trig_sel = 3'($urandom);
         end
         bus.rd_ready = ($urandom_range(0, 9) < 6);
         if ($urandom_range(0, 1) == 1) drive_sample(3'($urandom));
         else bus.sample_valid = 0;
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
